// File: rtl/upsampler_pkg.sv
// upsampler_pkg: shared FSM states, mode encodings and factor clamp for upsampler_iq
package upsampler_pkg;
   typedef enum logic {IDLE, EMIT} state_t;
   localparam logic MODE_ZERO = 1'b0;
   localparam logic MODE_HOLD = 1'b1;
   function automatic int unsigned clamp_factor(input int unsigned f, input int unsigned max_l);
      return (f == 32'd0) ? 32'd1 : (f > max_l) ? max_l : f;
   endfunction
endpackage

// File: rtl/upsampler_phase_cnt.sv
// upsampler_phase_cnt: per-symbol phase counter with load, advance and terminal count
module upsampler_phase_cnt #(
   parameter int FW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          adv,
   input  logic [FW-1:0] leff,
   output logic [FW-1:0] phase,
   output logic          tc
);
   assign tc = phase == leff - 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase <= '0;
      else if (load) phase <= '0;
      else if (adv) phase <= tc ? '0 : phase + 1'b1;
   end
endmodule

// File: rtl/upsampler_iq.sv
// upsampler_iq: I/Q symbol upsampler by factor L with zero-stuff or sample-and-hold
module upsampler_iq
   import upsampler_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int MAX_L  = 16,
   parameter int FW     = $clog2(MAX_L) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FW-1:0]     factor,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_i,
   input  logic [DATA_W-1:0] in_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_i,
   output logic [DATA_W-1:0] out_q,
   output logic              out_first
);
   state_t            state;
   logic [DATA_W-1:0] sym_i, sym_q;
   logic              mode_r;
   logic [FW-1:0]     leff, leff_n, phase;
   logic              tc, in_xfer, out_xfer;
   assign leff_n   = FW'(clamp_factor(32'(factor), MAX_L));
   // in_ready never looks at in_valid so no combinational loop forms upstream
   assign in_ready = !rst && (state == IDLE || (tc && out_ready));
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   upsampler_phase_cnt #(.FW(FW)) u_phase (
      .clk   (clk),
      .rst   (rst),
      .load  (in_xfer),
      .adv   (out_xfer),
      .leff  (leff),
      .phase (phase),
      .tc    (tc)
   );
   // outputs are registered one step ahead: they always show the current phase's sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_first <= 1'b0;
         sym_i     <= '0;
         sym_q     <= '0;
         mode_r    <= MODE_ZERO;
         leff      <= FW'(1);
      end else if (in_xfer) begin
         state     <= EMIT;
         out_valid <= 1'b1;
         out_i     <= in_i;
         out_q     <= in_q;
         out_first <= 1'b1;
         sym_i     <= in_i;
         sym_q     <= in_q;
         mode_r    <= mode;
         leff      <= leff_n;
      end else if (out_xfer) begin
         state     <= tc ? IDLE : EMIT;
         out_valid <= !tc;
         out_i     <= (!tc && mode_r == MODE_HOLD) ? sym_i : '0;
         out_q     <= (!tc && mode_r == MODE_HOLD) ? sym_q : '0;
         out_first <= 1'b0;
      end
   end
endmodule

// File: tb/tb_upsampler_iq.sv
// tb_upsampler_iq: directed checks of zero-stuff, hold, backpressure, clamp and reset
module tb_upsampler_iq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] factor = '0;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_i = '0, in_q = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_i, out_q;
   logic       out_first;
   int         n_cmp = 0, n_err = 0;
   upsampler_iq #(.DATA_W(4), .MAX_L(16)) dut (
      .clk(clk), .rst(rst), .factor(factor), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
      .out_first(out_first)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic v, input logic [3:0] i, input logic [3:0] q, input logic f);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".i"}, 32'(out_i), 32'(i));
      chk({tag, ".q"}, 32'(out_q), 32'(q));
      chk({tag, ".first"}, 32'(out_first), 32'(f));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      int cnt;
      #2;
      chk_out("reset", 0, 4'h0, 4'h0, 0);
      chk("reset.in_ready", 32'(in_ready), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      // zero-stuff L=4, symbol (3,-5)
      factor = 5'd4; mode = 1'b0; in_i = 4'h3; in_q = 4'hb; in_valid = 1'b1;
      #1 chk("zs.in_ready_idle", 32'(in_ready), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         chk_out($sformatf("zs%0d", k), 1, k == 0 ? 4'h3 : 4'h0, k == 0 ? 4'hb : 4'h0, k == 0);
         chk($sformatf("zs%0d.in_ready", k), 32'(in_ready), 32'(k == 3));
      end
      @(negedge clk); #1 chk_out("zs.idle", 0, 4'h0, 4'h0, 0);
      // hold L=4, back-to-back (7,1) then (-1,-3)
      factor = 5'd4; mode = 1'b1; in_i = 4'h7; in_q = 4'h1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin in_i = 4'hf; in_q = 4'hd; end
         if (k == 4) in_valid = 1'b0;
         #1;
         chk_out($sformatf("hold%0d", k), 1, k < 4 ? 4'h7 : 4'hf, k < 4 ? 4'h1 : 4'hd, k % 4 == 0);
         chk($sformatf("hold%0d.in_ready", k), 32'(in_ready), 32'(k % 4 == 3));
      end
      @(negedge clk); #1 chk_out("hold.idle", 0, 4'h0, 4'h0, 0);
      // backpressure L=3 with factor changed during the stall
      factor = 5'd3; mode = 1'b0; in_i = 4'h5; in_q = 4'h9; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      #1 chk_out("bp0", 1, 4'h5, 4'h9, 1);
      @(negedge clk); #1 chk_out("bp1", 1, 4'h0, 4'h0, 0);
      out_ready = 1'b0; factor = 5'd8; mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk_out($sformatf("bp_stall%0d", k), 1, 4'h0, 4'h0, 0);
         chk($sformatf("bp_stall%0d.in_ready", k), 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk); #1 chk_out("bp2", 1, 4'h0, 4'h0, 0);
      chk("bp2.in_ready", 32'(in_ready), 1);
      @(negedge clk); #1 chk_out("bp.idle", 0, 4'h0, 4'h0, 0);
      // clamp: factor 0 -> L=1, one sample per cycle
      factor = 5'd0; mode = 1'b0; in_i = 4'h1; in_q = 4'h1; in_valid = 1'b1;
      @(negedge clk); in_i = 4'h3; in_q = 4'h3;
      #1 chk_out("l1a", 1, 4'h1, 4'h1, 1);
      chk("l1a.in_ready", 32'(in_ready), 1);
      @(negedge clk); in_valid = 1'b0;
      #1 chk_out("l1b", 1, 4'h3, 4'h3, 1);
      @(negedge clk); #1 chk_out("l1.idle", 0, 4'h0, 4'h0, 0);
      // clamp: factor 31 -> 16 samples
      factor = 5'd31; mode = 1'b1; in_i = 4'hd; in_q = 4'h3; in_valid = 1'b1;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         if (!out_valid) break;
         cnt++;
      end
      chk("clamp31.count", 32'(cnt), 16);
      // reset at phase 2 of an L=8 symbol
      factor = 5'd8; mode = 1'b1; in_i = 4'h7; in_q = 4'h7; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1 chk_out("rs.ph2", 1, 4'h7, 4'h7, 0);
      rst = 1'b1;
      #1 chk_out("rs.async", 0, 4'h0, 4'h0, 0);
      chk("rs.in_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0; factor = 5'd2; mode = 1'b0; in_i = 4'h1; in_q = 4'hf; in_valid = 1'b1;
      #1 chk("rs.in_ready_rel", 32'(in_ready), 1);
      @(negedge clk); in_valid = 1'b0;
      #1 chk_out("rs.new0", 1, 4'h1, 4'hf, 1);
      @(negedge clk); #1 chk_out("rs.new1", 1, 4'h0, 4'h0, 0);
      @(negedge clk); #1 chk_out("rs.idle", 0, 4'h0, 4'h0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
